wb_raxm_master: RTL and testbench
=================================

WB_RAXM_MASTER -- requirements
Module: wb_raxm_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, SHALL set the multiplier register base: operand A at +0x0, operand B at +0x4, result at +0x8.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles a transaction waits for ack before aborting (range 1..65535).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed first below.
REQ-004 wb_clk_i  input  1  clock; all logic on rising edge.
REQ-005 wb_rst_ni  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  single-cycle request to run one multiply; sampled only in IDLE.
REQ-007 op_a_i  input  16  operand A; captured on accepted start.
REQ-008 op_b_i  input  16  operand B; captured on accepted start.
REQ-009 busy_o  output  1  high from the cycle after an accepted start until the DONE/ABORT cycle, inclusive.
REQ-010 done_o  output  1  one-cycle pulse, result_o valid.
REQ-011 err_o  output  1  one-cycle pulse, transaction timed out.
REQ-012 result_o  output  32  last read result; holds until the next successful read.
REQ-013 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master strobes.
REQ-014 wbm_adr_o  output  32  byte address; wbm_sel_o  output  4  byte select, always 4'hF during a transaction.
REQ-015 wbm_dat_o  output  32  write data; wbm_dat_i  input  32  read data; wbm_ack_i  input  1  slave acknowledge.

Function
REQ-016 FSM states SHALL be IDLE, WR_A, GAP_A, WR_B, GAP_B, RD_RES, DONE, ABORT.
REQ-017 IDLE: start_i=1 SHALL capture op_a_i/op_b_i and move to WR_A next cycle; start_i outside IDLE SHALL be ignored.
REQ-018 WR_A: cyc=stb=we=1, adr=BASE_ADDR, dat_o={16'h0,A}; on ack go to GAP_A.
REQ-019 WR_B: cyc=stb=we=1, adr=BASE_ADDR+4, dat_o={16'h0,B}; on ack go to GAP_B.
REQ-020 GAP_A/GAP_B: cyc=stb=0 for exactly one cycle, then WR_B / RD_RES respectively.
REQ-021 RD_RES: cyc=stb=1, we=0, adr=BASE_ADDR+8; on ack, result_o SHALL load wbm_dat_i in that same edge, go to DONE.
REQ-022 DONE: done_o=1 for one cycle, then IDLE; ABORT: err_o=1 for one cycle, then IDLE; result_o unchanged on abort.
REQ-023 Outside WR_A/WR_B/RD_RES, cyc, stb, we SHALL be 0; adr and dat_o SHALL be 0 in IDLE.
REQ-024 cyc/stb SHALL remain asserted and adr/dat_o/we stable while waiting for ack (classic handshake; no pipelining).
REQ-025 A wait counter SHALL clear on entry to each of WR_A/WR_B/RD_RES and increment every cycle without ack; when it reaches TIMEOUT with ack still low, the FSM SHALL drop cyc/stb and enter ABORT next cycle.
REQ-026 ack on the same cycle the counter reaches TIMEOUT SHALL be honored as success.
REQ-027 wbm_ack_i while cyc=0 SHALL be ignored.
REQ-028 Minimum latency start accepted -> done_o, with zero-wait acks, SHALL be 7 cycles.

Reset
REQ-029 wb_rst_ni=0 SHALL immediately force IDLE and all outputs to 0 (cyc, stb, we, sel, adr, dat_o, busy, done, err, result_o), regardless of state.
REQ-030 Reset asserted mid-transaction SHALL abandon it with no done_o or err_o; the first start after release SHALL begin a fresh WR_A.

Verification
REQ-031 A=16'h0012, B=16'h0034, slave acks every request next cycle, returns 32'h0000_03A8 -> writes 0x12 @BASE, 0x34 @BASE+4, read @BASE+8, done_o pulse, result_o=32'h3A8, busy_o low after.
REQ-032 Slave inserts 3 wait states on each access -> strobes/address/data held stable during waits, one idle cycle between transfers, done_o still single pulse.
REQ-033 Slave never acks WR_B, TIMEOUT=4 -> cyc drops after 4 wait cycles, err_o one pulse, result_o keeps previous value, next start works.
REQ-034 start_i pulsed while busy_o=1 with new operands -> ignored; captured operands from first start used.
REQ-035 wb_rst_ni low during RD_RES wait -> all outputs 0 asynchronously, no done_o/err_o; after release a new start completes normally.
REQ-036 Stray wbm_ack_i in IDLE and GAP cycles -> no state change, no output change.

Source files
------------

// File: rtl/wb_raxm_master.sv
// Wishbone classic master that runs one multiply on a memory-mapped multiplier.
// It writes operand A, then operand B, then reads the result, aborting any access that waits too long for ack.
module wb_raxm_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [15:0] op_a_i,
  input  logic [15:0] op_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] result_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR_A, GAP_A, WR_B, GAP_B, RD_RES, DONE, ABORT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        bus_req;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Shared wait handling for the three bus states: ack wins over timeout on the same cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bus_req  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = op_a_i;
          b_d     = op_b_i;
          cnt_d   = '0;
          state_d = WR_A;
        end
      end
      WR_A, WR_B, RD_RES: begin
        bus_req = 1'b1;
        if (wbm_ack_i) begin
          cnt_d = '0;
          case (state_q)
            WR_A:    state_d = GAP_A;
            WR_B:    state_d = GAP_B;
            default: begin
              result_d = wbm_dat_i;
              state_d  = DONE;
            end
          endcase
        end else if (cnt_q == TO_CNT) begin
          cnt_d   = '0;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP_A: begin
        cnt_d   = '0;
        state_d = WR_B;
      end
      GAP_B: begin
        cnt_d   = '0;
        state_d = RD_RES;
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from registered state, so they hold steady across wait states.
  always_comb begin
    wbm_cyc_o = bus_req;
    wbm_stb_o = bus_req;
    wbm_we_o  = 1'b0;
    wbm_sel_o = bus_req ? 4'hF : 4'h0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    unique case (state_q)
      WR_A: begin
        wbm_we_o  = 1'b1;
        wbm_adr_o = BASE_ADDR;
        wbm_dat_o = {16'h0, a_q};
      end
      WR_B: begin
        wbm_we_o  = 1'b1;
        wbm_adr_o = BASE_ADDR + 32'h4;
        wbm_dat_o = {16'h0, b_q};
      end
      RD_RES: wbm_adr_o = BASE_ADDR + 32'h8;
      default: ;
    endcase
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign err_o    = (state_q == ABORT);
  assign result_o = result_q;

endmodule

// File: tb/tb_wb_raxm_master.sv
// Bench for wb_raxm_master: a transaction-level model expands each start into the expected
// per-cycle bus picture (from wait counts), drives the slave from it and checks the DUT every cycle.
module tb_wb_raxm_master;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] result_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;

  wb_raxm_master #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .op_a_i(op_a), .op_b_i(op_b),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .wbm_cyc_o(cyc_o), .wbm_stb_o(stb_o), .wbm_we_o(we_o), .wbm_adr_o(adr_o),
    .wbm_sel_o(sel_o), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cyc, we, done, err, ack, rd, ld;
    logic [31:0] adr, dat, rdat;
  } exp_t;
  typedef struct { logic [31:0] adr, dat; logic we; } log_t;

  exp_t q[$];
  log_t blog[$];
  logic [31:0] m_result = '0;
  int ntests = 0, nfail = 0;
  int cyc_n = 0, start_cyc = 0, done_cyc = 0;
  int done_cnt = 0, err_cnt = 0, cyc_hi = 0;
  bit pend = 0, stray_en = 0, arm = 0;
  logic [15:0] pa, pb;
  int pw0, pw1, pw2;
  logic [31:0] prdat;

  task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    e.ack  = 1'($urandom_range(0, 1));
    e.rdat = $urandom;
    return e;
  endfunction

  // One access: w wait cycles then ack, or TO+1 unacked cycles then an abort cycle.
  task automatic push_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input int w, input logic rd, input logic [31:0] rdat, output bit ok);
    exp_t e;
    int n;
    ok = (w <= TO);
    n  = ok ? w + 1 : TO + 1;
    for (int k = 0; k < n; k++) begin
      e = '{default: '0};
      e.cyc = 1'b1; e.we = we; e.adr = adr; e.dat = dat; e.rd = rd;
      e.ack = ok && (k == w);
      e.ld  = rd && e.ack;
      e.rdat = e.ld ? rdat : $urandom;
      q.push_back(e);
    end
    if (!ok) begin
      e = blank();
      e.err = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic push_txn();
    bit ok;
    push_access(1'b1, BASE, {16'h0, pa}, pw0, 1'b0, 32'h0, ok);
    if (!ok) return;
    q.push_back(blank());
    push_access(1'b1, BASE + 32'h4, {16'h0, pb}, pw1, 1'b0, 32'h0, ok);
    if (!ok) return;
    q.push_back(blank());
    push_access(1'b0, BASE + 32'h8, 32'h0, pw2, 1'b1, prdat, ok);
    if (ok) begin
      exp_t e;
      e = blank();
      e.done = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    bit ok;
    #2 rst_n = 1'b0;
    #1;
    ok = !cyc_o && !stb_o && !we_o && sel_o == 4'h0 && adr_o == 0 && dat_o == 0 &&
         !busy_o && !done_o && !err_o && result_o == 0;
    chk(ok, "reset_mid_rd", {adr_o | dat_o | result_o, 25'h0, cyc_o, stb_o, we_o, busy_o, done_o, err_o, |sel_o}, 64'h0);
    q.delete();
    m_result = '0;
    start_i = 1'b0;
    ack_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    arm = 0;
  endtask

  task automatic tick();
    exp_t c;
    bit idle, ok, adr_ok, dat_ok;
    @(negedge clk);
    cyc_n++;
    idle = (q.size() == 0);
    c = idle ? blank() : q.pop_front();
    adr_ok = !(c.cyc || idle) || adr_o === c.adr;
    dat_ok = !((c.cyc && c.we) || idle) || dat_o === c.dat;
    ok = cyc_o === c.cyc && stb_o === c.cyc && we_o === (c.cyc & c.we) &&
         sel_o === (c.cyc ? 4'hF : 4'h0) && busy_o === !idle && done_o === c.done &&
         err_o === c.err && result_o === m_result && adr_ok && dat_ok;
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL cycle %0d: got cyc=%b stb=%b we=%b sel=%h busy=%b done=%b err=%b adr=%h dat=%h res=%h; expected cyc=%b we=%b busy=%b done=%b err=%b adr=%h dat=%h res=%h",
               cyc_n, cyc_o, stb_o, we_o, sel_o, busy_o, done_o, err_o, adr_o, dat_o, result_o,
               c.cyc, c.we, !idle, c.done, c.err, c.adr, c.dat, m_result);
    end
    if (done_o) begin done_cnt++; done_cyc = cyc_n; end
    if (err_o) err_cnt++;
    if (cyc_o) cyc_hi++;
    if (c.cyc && c.ack) blog.push_back('{adr: adr_o, dat: dat_o, we: we_o});
    ack_i = c.ack;
    dat_i = c.rdat;
    if (c.ld) m_result = c.rdat;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    if (idle && pend) begin
      start_i = 1'b1; op_a = pa; op_b = pb;
      push_txn();
      pend = 0;
      start_cyc = cyc_n;
    end else begin
      start_i = !idle && stray_en && ($urandom_range(0, 2) == 0);
    end
    if (arm && c.rd && !c.ack) do_reset();
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int w0, input int w1,
                         input int w2, input logic [31:0] rdat);
    int guard = 0;
    pa = a; pb = b; pw0 = w0; pw1 = w1; pw2 = w2; prdat = rdat;
    pend = 1;
    blog.delete();
    done_cnt = 0; err_cnt = 0; cyc_hi = 0;
    do begin
      tick();
      guard++;
    end while ((pend || q.size() != 0) && guard < 200);
    chk(guard < 200, "txn_bound", 64'(guard), 64'd200);
    tick();
  endtask

  initial begin
    #3;
    chk(!cyc_o && !stb_o && !we_o && sel_o == 0 && adr_o == 0 && dat_o == 0 && !busy_o &&
        !done_o && !err_o && result_o == 0, "reset_state",
        {adr_o | dat_o | result_o, 25'h0, cyc_o, stb_o, we_o, busy_o, done_o, err_o, |sel_o}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // Basic multiply with zero-wait acks
    run_txn(16'h0012, 16'h0034, 0, 0, 0, 32'h0000_03A8);
    chk(blog.size() == 3, "log_size", 64'(blog.size()), 64'd3);
    if (blog.size() == 3) begin
      chk(blog[0].adr == BASE && blog[0].dat == 32'h12 && blog[0].we, "wr_a", {blog[0].adr, blog[0].dat}, {BASE, 32'h12});
      chk(blog[1].adr == BASE + 4 && blog[1].dat == 32'h34 && blog[1].we, "wr_b", {blog[1].adr, blog[1].dat}, {BASE + 32'h4, 32'h34});
      chk(blog[2].adr == BASE + 8 && !blog[2].we, "rd_res", {blog[2].adr, 31'h0, blog[2].we}, {BASE + 32'h8, 32'h0});
    end
    chk(done_cyc - start_cyc + 1 == 7, "latency", 64'(done_cyc - start_cyc + 1), 64'd7);
    chk(result_o == 32'h3A8 && !busy_o && done_cnt == 1, "result_3a8", {result_o, 31'h0, busy_o}, {32'h3A8, 32'h0});

    // Three wait states on each access
    run_txn(16'h1111, 16'h2222, 3, 3, 3, 32'hDEAD_BEEF);
    chk(cyc_hi == 12 && done_cnt == 1, "waits3", {32'(cyc_hi), 32'(done_cnt)}, {32'd12, 32'd1});

    // WR_B never acked: WR_A one cycle, WR_B TO+1 cycles, then abort
    run_txn(16'h0001, 16'h0002, 0, 99, 0, 32'h0);
    chk(err_cnt == 1 && done_cnt == 0 && cyc_hi == 6, "timeout", {32'(err_cnt), 16'(done_cnt), 16'(cyc_hi)}, {32'd1, 16'd0, 16'd6});
    chk(result_o == 32'hDEAD_BEEF, "result_kept", 64'(result_o), 64'hDEAD_BEEF);
    run_txn(16'h0001, 16'h0002, 0, 0, 0, 32'h55);
    chk(result_o == 32'h55 && done_cnt == 1, "after_abort", 64'(result_o), 64'h55);

    // Restarts while busy are ignored
    stray_en = 1;
    run_txn(16'h0005, 16'h0007, 2, 2, 2, 32'h77);
    stray_en = 0;
    chk(blog.size() == 3 && blog[0].dat == 32'h5 && blog[1].dat == 32'h7, "ops_kept",
        {blog[0].dat, blog[1].dat}, {32'h5, 32'h7});

    // Reset in the middle of the RD_RES wait
    arm = 1;
    run_txn(16'h0009, 16'h0009, 0, 0, 3, 32'h99);
    chk(done_cnt == 0 && err_cnt == 0 && result_o == 0, "reset_no_pulse",
        {16'(done_cnt), 16'(err_cnt), result_o}, 64'h0);
    run_txn(16'h0003, 16'h0004, 0, 1, 0, 32'h1234);
    chk(result_o == 32'h1234 && done_cnt == 1, "after_reset", 64'(result_o), 64'h1234);

    // Random traffic, including acks on the TIMEOUT cycle and stray starts/acks
    stray_en = 1;
    for (int i = 0; i < 200; i++) begin
      run_txn(16'($urandom), 16'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 5), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
